// File: rtl/trap_redirect_unit.sv
// Converts trap, trap-return and single-step events into a timed flush followed by a
// handshaked PC redirect to fetch. Optional event counters: define TRAP_REDIRECT_TRACE_EN.
module trap_redirect_unit #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned XLEN         = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            exception,
   input  logic            eret,
   input  logic            single_step,
   input  logic            retire,
   input  logic            csr_stall,
   input  logic [XLEN-1:0] evec,
   input  logic [XLEN-1:0] epc,
   input  logic            redirect_ready,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            redirect_is_eret,
   output logic            flush,
   output logic            stall_pipe
`ifdef TRAP_REDIRECT_TRACE_EN
   ,
   output logic [31:0]     trap_count,
   output logic [31:0]     eret_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      REDIRECT
   } state_t;

   localparam logic [3:0]      CNT_INIT   = 4'(FLUSH_CYCLES - 1);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   state_t          state_q, state_d;
   logic [XLEN-1:0] target_q, target_d;
   logic            kind_q, kind_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            event_any;
   logic            event_is_eret;

   // exception outranks eret; single-step only fires on an actual retirement
   assign event_any     = exception || eret || (single_step && retire);
   assign event_is_eret = !exception && eret;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         target_q <= '0;
         kind_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         kind_q   <= kind_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      target_d         = target_q;
      kind_d           = kind_q;
      cnt_d            = cnt_q;
      flush            = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;
      redirect_is_eret = 1'b0;
      case (state_q)
         IDLE: begin
            if (event_any) begin
               state_d  = FLUSH;
               cnt_d    = CNT_INIT;
               kind_d   = event_is_eret;
               target_d = event_is_eret ? epc : evec;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            if (cnt_q == '0) begin
               state_d = REDIRECT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         REDIRECT: begin
            redirect_valid   = 1'b1;
            redirect_pc      = target_q & ALIGN_MASK;
            redirect_is_eret = kind_q;
            if (redirect_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign stall_pipe = (state_q != IDLE) || csr_stall;

`ifdef TRAP_REDIRECT_TRACE_EN
   logic accept_trap;
   logic accept_eret;

   assign accept_trap = (state_q == IDLE) && event_any && !event_is_eret;
   assign accept_eret = (state_q == IDLE) && event_is_eret;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trap_count <= '0;
         eret_count <= '0;
      end else begin
         if (accept_trap) trap_count <= trap_count + 32'd1;
         if (accept_eret) eret_count <= eret_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_trap_redirect_unit.sv
// Scoreboard bench for trap_redirect_unit: stimulus pushes per-cycle and per-redirect
// expectations from a sequence-level model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_trap_redirect_unit;

   localparam int unsigned F  = 2;
   localparam int unsigned XL = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          exception = 1'b0;
   logic          eret = 1'b0;
   logic          single_step = 1'b0;
   logic          retire = 1'b0;
   logic          csr_stall = 1'b0;
   logic [XL-1:0] evec = '0;
   logic [XL-1:0] epc = '0;
   logic          redirect_ready = 1'b0;
   logic          redirect_valid;
   logic [XL-1:0] redirect_pc;
   logic          redirect_is_eret;
   logic          flush;
   logic          stall_pipe;
`ifdef TRAP_REDIRECT_TRACE_EN
   logic [31:0]   trap_count;
   logic [31:0]   eret_count;
`endif

   always #5 clk = ~clk;

   trap_redirect_unit #(.FLUSH_CYCLES(F), .XLEN(XL)) dut (
      .clk              (clk),
      .reset            (reset),
      .exception        (exception),
      .eret             (eret),
      .single_step      (single_step),
      .retire           (retire),
      .csr_stall        (csr_stall),
      .evec             (evec),
      .epc              (epc),
      .redirect_ready   (redirect_ready),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .redirect_is_eret (redirect_is_eret),
      .flush            (flush),
      .stall_pipe       (stall_pipe)
`ifdef TRAP_REDIRECT_TRACE_EN
      ,
      .trap_count       (trap_count),
      .eret_count       (eret_count)
`endif
   );

   typedef struct {
      logic          fl;
      logic          st;
      logic          vl;
      logic          ie;
      logic [XL-1:0] pc;
   } cyc_t;

   typedef struct {
      logic [XL-1:0] pc;
      logic          ie;
   } txn_t;

   cyc_t cq[$];
   txn_t tq[$];

   int checks = 0;
   int passes = 0;

   // Sequence-level model: flush cycles still owed, redirect pending, latched target/kind
   int            m_flush_left = 0;
   bit            m_redir = 1'b0;
   logic [XL-1:0] m_tgt = '0;
   logic          m_ie = 1'b0;
   logic [31:0]   m_trap = '0;
   logic [31:0]   m_eret = '0;

   task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input bit exc, input bit er, input bit ss, input bit ret, input bit cs,
                       input logic [XL-1:0] ev, input logic [XL-1:0] ep, input bit rdy);
      cyc_t e;
      txn_t t;
      @(posedge clk);
      #1;
      exception = exc; eret = er; single_step = ss; retire = ret; csr_stall = cs;
      evec = ev; epc = ep; redirect_ready = rdy;
      e.fl = 1'b0; e.st = cs; e.vl = 1'b0; e.ie = 1'b0; e.pc = '0;
      if (m_redir) begin
         e.vl = 1'b1; e.st = 1'b1; e.pc = m_tgt; e.ie = m_ie;
         if (rdy) begin
            t.pc = m_tgt; t.ie = m_ie;
            tq.push_back(t);
            m_redir = 1'b0;
         end
      end else if (m_flush_left > 0) begin
         e.fl = 1'b1; e.st = 1'b1;
         m_flush_left--;
         if (m_flush_left == 0) m_redir = 1'b1;
      end else if (exc || er || (ss && ret)) begin
         m_ie  = !exc && er;
         m_tgt = m_ie ? {ep[XL-1:2], 2'b00} : {ev[XL-1:2], 2'b00};
         m_flush_left = F;
         if (m_ie) m_eret = m_eret + 32'd1;
         else      m_trap = m_trap + 32'd1;
      end
      cq.push_back(e);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 32'h0, rdy);
   endtask

   initial begin : monitor
      cyc_t e;
      txn_t t;
      forever begin
         @(negedge clk);
         if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("flush", 32'(flush), 32'(e.fl));
            chk("stall_pipe", 32'(stall_pipe), 32'(e.st));
            chk("redirect_valid", 32'(redirect_valid), 32'(e.vl));
            if (e.vl) begin
               chk("redirect_pc", redirect_pc, e.pc);
               chk("redirect_is_eret", 32'(redirect_is_eret), 32'(e.ie));
            end
         end
         if (!reset && redirect_valid && redirect_ready) begin
            if (tq.size() == 0) begin
               checks++;
               $display("FAIL txn_unexpected: got redirect %0h expected none at %0t", redirect_pc, $time);
            end else begin
               t = tq.pop_front();
               chk("txn_pc", redirect_pc, t.pc);
               chk("txn_is_eret", 32'(redirect_is_eret), 32'(t.ie));
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      bit r_exc, r_er, r_ss, r_ret, r_cs, r_rdy;
      #2;
      chk("reset_valid", 32'(redirect_valid), 32'h0);
      chk("reset_pc", redirect_pc, 32'h0);
      chk("reset_is_eret", 32'(redirect_is_eret), 32'h0);
      chk("reset_flush", 32'(flush), 32'h0);
      chk("reset_stall", 32'(stall_pipe), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // single trap
      step(1, 0, 0, 0, 0, 32'h0000_0104, 32'h0, 1);
      idle(5, 1);
      // return with misaligned epc, then simultaneous exception+eret
      step(0, 1, 0, 0, 0, 32'h0, 32'h0000_2002, 1);
      idle(5, 1);
      step(1, 1, 0, 0, 0, 32'h0000_0100, 32'h0000_2000, 1);
      idle(5, 1);
      // backpressure with an ignored exception during the wait
      step(1, 0, 0, 0, 0, 32'h0000_0300, 32'h0, 0);
      for (int i = 0; i < int'(F); i++) step(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
      for (int i = 0; i < 5; i++) step(i == 2, 0, 0, 0, 0, 32'h0000_0500, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
      idle(2, 1);
      // single step
      for (int i = 0; i < 25; i++) step(0, 0, 1, (i == 10) || (i == 20), 0, 32'h0000_0800, 32'h0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 32'h0000_0800, 32'h0, 1);
      idle(3, 1);
      // asynchronous reset during the first flush cycle
      step(1, 0, 0, 0, 0, 32'h0000_0040, 32'h0, 1);
      @(posedge clk);
      #1 exception = 1'b0;
      chk("pre_reset_flush", 32'(flush), 32'h1);
      #1 reset = 1'b1;
      #1;
      chk("async_reset_flush", 32'(flush), 32'h0);
      chk("async_reset_stall", 32'(stall_pipe), 32'h0);
      chk("async_reset_valid", 32'(redirect_valid), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      m_flush_left = 0; m_redir = 1'b0;
`ifdef TRAP_REDIRECT_TRACE_EN
      m_trap = '0; m_eret = '0;
`endif
      step(0, 1, 0, 0, 0, 32'h0, 32'h0000_0088, 1);
      idle(6, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r_exc = ($urandom_range(7) == 0);
         r_er  = ($urandom_range(7) == 0);
         r_ss  = ($urandom_range(3) == 0);
         r_ret = ($urandom_range(1) == 0);
         r_cs  = ($urandom_range(3) == 0);
         r_rdy = ($urandom_range(1) == 0);
         step(r_exc, r_er, r_ss, r_ret, r_cs, $urandom, $urandom, r_rdy);
      end
      idle(int'(F) + 4, 1);
      chk("txn_drained", 32'(tq.size()), 32'h0);

`ifdef TRAP_REDIRECT_TRACE_EN
      chk("trap_count", trap_count, m_trap);
      chk("eret_count", eret_count, m_eret);
      @(posedge clk);
      #1 force dut.trap_count = 32'hFFFF_FFFF;
      #1 release dut.trap_count;
      m_trap = 32'hFFFF_FFFF;
      step(1, 0, 0, 0, 0, 32'h0000_0104, 32'h0, 1);
      idle(int'(F) + 3, 1);
      chk("trap_count_wrap", trap_count, m_trap);
`endif

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
